// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential 16-bit restoring divider.
package div_pkg;
    localparam int W = 16;
    localparam int DIV_STEPS = 16;
    localparam logic [W-1:0] QUOT_DZ = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int WS = W
) (
    input  logic [WS-1:0] r,
    input  logic          a_msb,
    input  logic [WS-1:0] b_mag,
    output logic [WS-1:0] r_next,
    output logic          q_bit
);
    logic [WS:0] r_sh;
    logic [WS:0] trial;

    // r < b_mag always holds, so the 17-bit difference lies in [-b_mag, b_mag-1]
    // and its top bit is a reliable sign.
    assign r_sh   = {r, a_msb};
    assign trial  = r_sh - {1'b0, b_mag};
    assign q_bit  = ~trial[WS];
    assign r_next = q_bit ? trial[WS-1:0] : r_sh[WS-1:0];
endmodule

// File: rtl/div_16_seq.sv
// Sequential 16-bit restoring divider, signed or unsigned, with start/busy/done handshake.
module div_16_seq
    import div_pkg::*;
#(
    parameter int WD = W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          op_sel,
    input  logic [WD-1:0] A,
    input  logic [WD-1:0] B,
    output logic [WD-1:0] quot,
    output logic [WD-1:0] rem,
    output logic          busy,
    output logic          done,
    output logic          v,
    output logic          n,
    output logic          dz
);
    localparam logic [WD-1:0] MIN_NEG = {1'b1, {(WD-1){1'b0}}};
    localparam logic [3:0]    CNT_TOP = 4'(DIV_STEPS - 1);

    state_t        state, state_nx;
    logic [3:0]    cnt;
    logic [WD-1:0] a_sh;
    logic [WD-1:0] b_mag;
    logic [WD-1:0] r_acc;
    logic          sel, sq, sr, zdiv;

    logic [WD-1:0] r_step;
    logic          q_step;
    logic [WD-1:0] a_in_mag, b_in_mag;
    logic [WD-1:0] q_signed, r_signed, final_q, final_r;
    logic          ovf;

    div_step #(.WS(WD)) u_step (
        .r      (r_step_in_r()),
        .a_msb  (a_sh[WD-1]),
        .b_mag  (b_mag),
        .r_next (r_step),
        .q_bit  (q_step)
    );

    function automatic logic [WD-1:0] r_step_in_r();
        return r_acc;
    endfunction

    assign a_in_mag = (op_sel && A[WD-1]) ? -A : A;
    assign b_in_mag = (op_sel && B[WD-1]) ? -B : B;

    // a_sh has become the unsigned quotient by the time FIX is reached.
    assign ovf      = sel & (a_sh == MIN_NEG) & ~sq;
    assign q_signed = sq ? -a_sh : a_sh;
    assign r_signed = sr ? -r_acc : r_acc;
    assign final_q  = ovf ? MIN_NEG : q_signed;
    assign final_r  = ovf ? '0 : r_signed;

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                // A zero divisor detours through FIX without the busy flag so
                // that it still resolves in a single clock.
                if (start) state_nx = (B == '0) ? FIX : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == 4'd0) state_nx = FIX;
            end
            FIX: begin
                busy     = ~zdiv;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_mag <= '0;
            r_acc <= '0;
            sel   <= 1'b0;
            sq    <= 1'b0;
            sr    <= 1'b0;
            zdiv  <= 1'b0;
            quot  <= '0;
            rem   <= '0;
            v     <= 1'b0;
            n     <= 1'b0;
            dz    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel   <= op_sel;
                        a_sh  <= a_in_mag;
                        b_mag <= b_in_mag;
                        sq    <= op_sel & (A[WD-1] ^ B[WD-1]);
                        sr    <= op_sel & A[WD-1];
                        r_acc <= '0;
                        cnt   <= CNT_TOP;
                        v     <= 1'b0;
                        if (B == '0) begin
                            zdiv <= 1'b1;
                            quot <= QUOT_DZ;
                            rem  <= A;
                            dz   <= 1'b1;
                            n    <= 1'b1;
                        end else begin
                            zdiv <= 1'b0;
                            dz   <= 1'b0;
                            n    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    a_sh  <= {a_sh[WD-2:0], q_step};
                    r_acc <= r_step;
                    cnt   <= cnt - 4'd1;
                end
                FIX: begin
                    if (!zdiv) begin
                        quot <= final_q;
                        rem  <= final_r;
                        v    <= ovf;
                        n    <= final_q[WD-1];
                        dz   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_16_seq.sv
// Self-checking bench for div_16_seq: arithmetic reference model plus directed literal checks.
module tb_div_16_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op_sel = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [15:0] quot, rem;
    logic        busy, done, v, n, dz;

    int n_cmp = 0;
    int n_bad = 0;

    div_16_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sel (op_sel),
        .A      (A),
        .B      (B),
        .quot   (quot),
        .rem    (rem),
        .busy   (busy),
        .done   (done),
        .v      (v),
        .n      (n),
        .dz     (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: truncating division, remainder follows the dividend.
    function automatic void ref_div(input logic op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic [15:0] r, output logic ov);
        int sa, sb, iq, ir;
        ov = 1'b0;
        if (op) begin
            if (a == 16'h8000 && b == 16'hFFFF) begin
                q  = 16'h8000;
                r  = 16'h0000;
                ov = 1'b1;
            end else begin
                sa = int'($signed(a));
                sb = int'($signed(b));
                iq = sa / sb;
                ir = sa % sb;
                q  = iq[15:0];
                r  = ir[15:0];
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Timeline model: expected outputs after every active edge.
    logic [15:0] e_quot = '0, e_rem = '0, p_q = '0, p_r = '0;
    logic        e_busy = 0, e_done = 0, e_v = 0, e_n = 0, e_dz = 0, p_v = 0;
    int          m_wait = 0;
    bit          m_cool = 0, m_isdz = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_quot = '0; e_rem = '0; e_busy = 0; e_done = 0;
            e_v = 0; e_n = 0; e_dz = 0;
            m_wait = 0; m_cool = 0; m_isdz = 0;
        end else begin
            e_done = 0;
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    e_done = 1;
                    e_busy = 0;
                    m_cool = 1;
                    if (!m_isdz) begin
                        e_quot = p_q; e_rem = p_r; e_v = p_v; e_n = p_q[15];
                    end
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else if (start) begin
                e_v = 0; e_n = 0; e_dz = 0;
                if (B == 16'h0000) begin
                    e_quot = 16'hFFFF; e_rem = A; e_dz = 1; e_n = 1;
                    m_isdz = 1; m_wait = 1; e_busy = 0;
                end else begin
                    ref_div(op_sel, A, B, p_q, p_r, p_v);
                    m_isdz = 0; m_wait = 17; e_busy = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cycle", {27'd0, quot, rem, busy, done, v, n, dz},
                     {27'd0, e_quot, e_rem, e_busy, e_done, e_v, e_n, e_dz});
    end

    // Runs one division; lat counts active edges from the accepting edge to the done sample.
    task automatic run_div(input logic op, input logic [15:0] a, input logic [15:0] b,
                           output int lat, output int bcnt);
        @(negedge clk);
        op_sel = op; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (busy) bcnt++;
    endtask

    task automatic dir(input string name, input logic op, input logic [15:0] a, input logic [15:0] b,
                       input int exp_lat, input logic [15:0] eq, input logic [15:0] er,
                       input logic ev, input logic en, input logic edz);
        int lat, bc;
        run_div(op, a, b, lat, bc);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_busy_cycles"}, 64'(bc), (exp_lat == 1) ? 64'd0 : 64'd17);
        chk({name, "_res"}, {29'd0, quot, rem, v, n, dz}, {29'd0, eq, er, ev, en, edz});
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {27'd0, quot, rem, busy, done, v, n, dz}, 64'd0);
        rst_n = 1'b1;

        dir("u_100_7",     0, 16'd100,   16'd7,      17, 16'd14,   16'd2,    0, 0, 0);
        dir("s_m100_7",    1, 16'hFF9C,  16'd7,      17, 16'hFFF2, 16'hFFFE, 0, 1, 0);
        dir("s_100_m7",    1, 16'd100,   16'hFFF9,   17, 16'hFFF2, 16'h0002, 0, 1, 0);
        dir("dz_u",        0, 16'd5,     16'd0,      1,  16'hFFFF, 16'd5,    0, 1, 1);
        dir("dz_s",        1, 16'd5,     16'd0,      1,  16'hFFFF, 16'd5,    0, 1, 1);
        dir("s_ovf",       1, 16'h8000,  16'hFFFF,   17, 16'h8000, 16'h0000, 1, 1, 0);
        dir("u_ffff_1",    0, 16'hFFFF,  16'd1,      17, 16'hFFFF, 16'h0000, 0, 1, 0);
        dir("u_ffff_fffe", 0, 16'hFFFF,  16'hFFFE,   17, 16'h0001, 16'h0001, 0, 0, 0);
        dir("s_m7_2",      1, 16'hFFF9,  16'd2,      17, 16'hFFFD, 16'hFFFF, 0, 1, 0);
        dir("s_min_1",     1, 16'h8000,  16'd1,      17, 16'h8000, 16'h0000, 0, 1, 0);
        dir("s_min_7",     1, 16'h8000,  16'd7,      17, 16'hEDB7, 16'hFFFF, 0, 1, 0);

        // start held high; operands wander after the accepting edge
        @(negedge clk);
        op_sel = 0; A = 16'd100; B = 16'd7; start = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!done && lat < 40) begin
            A = 16'($urandom_range(0, 65535));
            B = 16'($urandom_range(0, 65535));
            op_sel = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        chk("hold_lat", 64'(lat), 64'd17);
        chk("hold_res", {32'd0, quot, rem}, {32'd0, 16'd14, 16'd2});
        op_sel = 0; A = 16'd200; B = 16'd9;
        lat = 0;
        @(negedge clk);
        lat++;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_next_lat", 64'(lat), 64'd19);
        chk("hold_next_res", {32'd0, quot, rem}, {32'd0, 16'd22, 16'd2});
        start = 1'b0;

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        op_sel = 0; A = 16'd1000; B = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {27'd0, quot, rem, busy, done, v, n, dz}, 64'd0);
        chk("mid_reset_state", 64'(dut.state), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dir("after_reset", 0, 16'd200, 16'd9, 17, 16'd22, 16'd2, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
